// File: rtl/register_file_sb.sv
// Integer register file with a per-register pending-write scoreboard.
// A post-reset sweep zeroes every entry before ops are accepted.
//
// state    | meaning
// ---------+-------------------------------------------------------------
// ST_CLEAR | sweeping bank[clear_idx] <= 0; writes/reserves ignored
// ST_READY | normal operation, terminal until next reset
module register_file_sb #(
    parameter int XLEN     = 32,
    parameter int NUM_REGS = 32,
    parameter int NUM_READ = 3,
    parameter int ZERO_REG = 1,
    parameter int BYPASS   = 1,
    localparam int AW      = $clog2(NUM_REGS)
) (
    input  logic                     CLK,
    input  logic                     RESET,
    output logic                     out_init_done,
    input  logic                     in_write_enable,
    input  logic [AW-1:0]            in_write_register_select,
    input  logic [XLEN-1:0]          in_write_data,
    input  logic                     in_reserve_enable,
    input  logic [AW-1:0]            in_reserve_register_select,
    output logic                     out_reserve_ready,
    input  logic [NUM_READ*AW-1:0]   in_read_register_select,
    output logic [NUM_READ*XLEN-1:0] out_read_data,
    output logic [NUM_READ-1:0]      out_read_pending
);

    typedef enum logic {ST_CLEAR, ST_READY} state_t;

    state_t            state;
    logic [AW-1:0]     clear_idx;
    logic [XLEN-1:0]   bank [NUM_REGS];
    logic [NUM_REGS-1:0] pending;
    logic              wr_ok;
    logic              res_ok;

    function automatic logic valid_idx(input logic [AW-1:0] idx);
        return (32'(idx) < NUM_REGS) && !((ZERO_REG != 0) && (idx == '0));
    endfunction

    always_ff @(posedge CLK or negedge RESET) begin
        if (!RESET) begin
            state         <= ST_CLEAR;
            clear_idx     <= '0;
            out_init_done <= 1'b0;
        end else begin
            case (state)
                ST_CLEAR: begin
                    clear_idx <= clear_idx + AW'(1);
                    if (clear_idx == AW'(NUM_REGS - 1)) begin
                        state         <= ST_READY;
                        out_init_done <= 1'b1;
                    end
                end
                ST_READY: ;
                default: state <= ST_CLEAR;
            endcase
        end
    end

    // out_init_done flips on the same edge as ST_READY, so it doubles as the op gate.
    assign wr_ok = out_init_done && in_write_enable && valid_idx(in_write_register_select);

    assign out_reserve_ready = out_init_done && valid_idx(in_reserve_register_select) &&
                               (!pending[in_reserve_register_select] ||
                                (in_write_enable &&
                                 in_write_register_select == in_reserve_register_select));
    assign res_ok = in_reserve_enable && out_reserve_ready;

    // Bank holds no reset; its contents are defined by the clear sweep.
    always_ff @(posedge CLK) begin
        if (state == ST_CLEAR) begin
            bank[clear_idx] <= '0;
        end else if (wr_ok) begin
            bank[in_write_register_select] <= in_write_data;
        end
    end

    // Reserve is applied after the retire so a same-index pair leaves the entry pending.
    always_ff @(posedge CLK or negedge RESET) begin
        if (!RESET) begin
            pending <= '0;
        end else begin
            if (wr_ok) begin
                pending[in_write_register_select] <= 1'b0;
            end
            if (res_ok) begin
                pending[in_reserve_register_select] <= 1'b1;
            end
        end
    end

    for (genvar i = 0; i < NUM_READ; i++) begin : g_rd
        logic [AW-1:0] sel;
        logic          sel_ok;
        logic          hit;

        assign sel    = in_read_register_select[i*AW +: AW];
        assign sel_ok = out_init_done && valid_idx(sel);
        assign hit    = (BYPASS != 0) && wr_ok && (in_write_register_select == sel);

        assign out_read_data[i*XLEN +: XLEN] = !sel_ok ? '0 :
                                               hit     ? in_write_data : bank[sel];
        assign out_read_pending[i] = sel_ok && !hit && pending[sel];
    end

endmodule

// File: tb/tb_register_file_sb.sv
// Directed bench for register_file_sb with default parameters (32x32, 3 read ports).
module tb_register_file_sb;
    localparam int XLEN = 32;
    localparam int AW   = 5;
    localparam int NR   = 3;

    logic             CLK = 1'b0;
    logic             RESET;
    logic             out_init_done;
    logic             in_write_enable;
    logic [AW-1:0]    in_write_register_select;
    logic [XLEN-1:0]  in_write_data;
    logic             in_reserve_enable;
    logic [AW-1:0]    in_reserve_register_select;
    logic             out_reserve_ready;
    logic [NR*AW-1:0] in_read_register_select;
    logic [NR*XLEN-1:0] out_read_data;
    logic [NR-1:0]    out_read_pending;

    int checks   = 0;
    int failures = 0;
    int rise;

    register_file_sb dut (
        .CLK                        (CLK),
        .RESET                      (RESET),
        .out_init_done              (out_init_done),
        .in_write_enable            (in_write_enable),
        .in_write_register_select   (in_write_register_select),
        .in_write_data              (in_write_data),
        .in_reserve_enable          (in_reserve_enable),
        .in_reserve_register_select (in_reserve_register_select),
        .out_reserve_ready          (out_reserve_ready),
        .in_read_register_select    (in_read_register_select),
        .out_read_data              (out_read_data),
        .out_read_pending           (out_read_pending)
    );

    always #5 CLK = ~CLK;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge CLK);
        #1;
    endtask

    task automatic set_rd(input int p, input logic [AW-1:0] sel);
        in_read_register_select[p*AW +: AW] = sel;
    endtask

    function automatic logic [XLEN-1:0] rd(input int p);
        return out_read_data[p*XLEN +: XLEN];
    endfunction

    initial begin
        RESET = 1'b0;
        in_write_enable = 1'b0;
        in_write_register_select = '0;
        in_write_data = '0;
        in_reserve_enable = 1'b0;
        in_reserve_register_select = '0;
        in_read_register_select = '0;

        // reset state
        #12;
        set_rd(0, 5'd3);
        in_reserve_register_select = 5'd3;
        #1;
        check("rst_init_done", {31'b0, out_init_done}, 32'd0);
        check("rst_reserve_ready", {31'b0, out_reserve_ready}, 32'd0);
        check("rst_read_data", out_read_data[31:0], 32'd0);
        check("rst_read_pending", {29'b0, out_read_pending}, 32'd0);

        // 1: sweep takes exactly 32 cycles
        @(negedge CLK);
        RESET = 1'b1;
        rise = 0;
        for (int c = 1; c <= 40; c++) begin
            tick();
            if (out_init_done && rise == 0) rise = c;
        end
        check("init_rise_cycle", rise, 32'd32);
        for (int r = 1; r < 32; r++) begin
            set_rd(0, AW'(r));
            #1;
            check("sweep_read_zero", rd(0), 32'd0);
        end
        check("sweep_pending_zero", {29'b0, out_read_pending}, 32'd0);

        // 2: bypass write x5
        in_write_enable = 1'b1;
        in_write_register_select = 5'd5;
        in_write_data = 32'hDEADBEEF;
        set_rd(1, 5'd5);
        #1;
        check("bypass_x5_same_cycle", rd(1), 32'hDEADBEEF);
        check("bypass_x5_pending", {31'b0, out_read_pending[1]}, 32'd0);
        tick();
        in_write_enable = 1'b0;
        #1;
        check("x5_next_cycle", rd(1), 32'hDEADBEEF);

        // 3: zero register
        in_write_enable = 1'b1;
        in_write_register_select = 5'd0;
        in_write_data = 32'h1234;
        in_reserve_enable = 1'b1;
        in_reserve_register_select = 5'd0;
        set_rd(0, 5'd0);
        #1;
        check("x0_read_same", rd(0), 32'd0);
        check("x0_pending_same", {31'b0, out_read_pending[0]}, 32'd0);
        check("x0_reserve_ready", {31'b0, out_reserve_ready}, 32'd0);
        tick();
        in_write_enable = 1'b0;
        in_reserve_enable = 1'b0;
        #1;
        check("x0_read_next", rd(0), 32'd0);
        check("x0_pending_next", {31'b0, out_read_pending[0]}, 32'd0);

        // 4: reserve x7, then retire it
        in_reserve_enable = 1'b1;
        in_reserve_register_select = 5'd7;
        #1;
        check("x7_reserve_ready", {31'b0, out_reserve_ready}, 32'd1);
        tick();
        in_reserve_enable = 1'b0;
        set_rd(0, 5'd7);
        set_rd(2, 5'd7);
        #1;
        check("x7_pending_p0", {31'b0, out_read_pending[0]}, 32'd1);
        check("x7_pending_p2", {31'b0, out_read_pending[2]}, 32'd1);
        check("x7_waw_refused", {31'b0, out_reserve_ready}, 32'd0);
        in_write_enable = 1'b1;
        in_write_register_select = 5'd7;
        in_write_data = 32'h55;
        #1;
        check("x7_wb_pending", {31'b0, out_read_pending[0]}, 32'd0);
        check("x7_wb_data", rd(0), 32'h55);
        check("x7_wb_ready", {31'b0, out_reserve_ready}, 32'd1);
        tick();
        in_write_enable = 1'b0;
        #1;
        check("x7_after_pending", {31'b0, out_read_pending[0]}, 32'd0);
        check("x7_after_data", rd(0), 32'h55);

        // 5: write and re-reserve x9 in the same cycle
        in_reserve_enable = 1'b1;
        in_reserve_register_select = 5'd9;
        tick();
        in_reserve_enable = 1'b0;
        set_rd(0, 5'd9);
        #1;
        check("x9_pending", {31'b0, out_read_pending[0]}, 32'd1);
        check("x9_ready_blocked", {31'b0, out_reserve_ready}, 32'd0);
        in_write_enable = 1'b1;
        in_write_register_select = 5'd9;
        in_write_data = 32'hA5;
        in_reserve_enable = 1'b1;
        #1;
        check("x9_wr_res_ready", {31'b0, out_reserve_ready}, 32'd1);
        tick();
        in_write_enable = 1'b0;
        in_reserve_enable = 1'b0;
        #1;
        check("x9_data", rd(0), 32'hA5);
        check("x9_pending_again", {31'b0, out_read_pending[0]}, 32'd1);

        // 6: reset mid-sweep restarts the sweep
        RESET = 1'b0;
        #1;
        check("rst2_init_done", {31'b0, out_init_done}, 32'd0);
        @(negedge CLK);
        RESET = 1'b1;
        set_rd(0, 5'd7);
        for (int c = 1; c <= 10; c++) begin
            tick();
            if (c == 3) check("clear_read_forced_zero", rd(0), 32'd0);
        end
        RESET = 1'b0;
        #1;
        check("mid_rst_init_done", {31'b0, out_init_done}, 32'd0);
        tick();
        tick();
        check("mid_rst_hold", {31'b0, out_init_done}, 32'd0);
        in_write_enable = 1'b1;
        in_write_register_select = 5'd20;
        in_write_data = 32'hFFFF;
        in_reserve_enable = 1'b1;
        in_reserve_register_select = 5'd3;
        @(negedge CLK);
        RESET = 1'b1;
        rise = 0;
        for (int c = 1; c <= 40; c++) begin
            tick();
            if (c == 30) begin
                in_write_enable = 1'b0;
                in_reserve_enable = 1'b0;
            end
            if (out_init_done && rise == 0) rise = c;
        end
        check("restart_rise_cycle", rise, 32'd32);
        set_rd(0, 5'd5);
        set_rd(1, 5'd20);
        set_rd(2, 5'd3);
        #1;
        check("x5_cleared", rd(0), 32'd0);
        check("clear_write_ignored", rd(1), 32'd0);
        check("clear_reserve_ignored", {31'b0, out_read_pending[2]}, 32'd0);
        check("x3_ready_after", {31'b0, out_reserve_ready}, 32'd1);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
